// File: rtl/msk_lbox_pkg.sv
// Shared definitions for the masked Clyde-128 L-box engine: rotation amounts,
// FSM encoding and a rotate that moves whole d-share bit groups.
package msk_lbox_pkg;

  localparam int MAX_D = 8;

  typedef logic [32*MAX_D-1:0] share_word_t;

  localparam int FWD_ROT [7] = '{12, 3, 17, 31, 26, 25, 15};
  localparam int INV_ROT [8] = '{25, 31, 20, 31, 26, 25, 17, 16};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  // Right-rotate a 32-bit word whose bits are d-share groups; only the low
  // 32*d bits of w are meaningful and the upper bits come back as zero.
  function automatic share_word_t share_rotr(input share_word_t w, input int n, input int d);
    share_word_t mask;
    mask = (share_word_t'(1) << (32 * d)) - share_word_t'(1);
    return ((w >> (n * d)) | (w << ((32 - n) * d))) & mask;
  endfunction

endpackage

// File: rtl/msk_lbox_if.sv
// Valid/ready bundle between the round datapath and the L-box engine.
interface msk_lbox_if #(
  parameter int D     = 2,
  parameter int NPAIR = 2
);
  localparam int SW = 64 * NPAIR * D;

  logic          in_valid;
  logic          in_ready;
  logic          in_inverse;
  logic [SW-1:0] in_state;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic          busy;

  modport master (
    output in_valid, in_inverse, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_inverse, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/msk_lbox_core.sv
// One masked L-box lane: forward or inverse Clyde L-box on a single word pair.
// Every step is a share-wise XOR of rotated words, so shares never mix.
module msk_lbox_core
  import msk_lbox_pkg::*;
#(
  parameter int D = 2
) (
  input  logic            inverse_i,
  input  logic [32*D-1:0] x_i,
  input  logic [32*D-1:0] y_i,
  output logic [32*D-1:0] a_o,
  output logic [32*D-1:0] b_o
);

  localparam int W = 32 * D;

  function automatic logic [W-1:0] rot(input logic [W-1:0] w, input int n);
    share_word_t t;
    t = share_rotr(share_word_t'(w), n, D);
    return t[W-1:0];
  endfunction

  logic [W-1:0] fa, fb, fc, fe;
  logic [W-1:0] ia, ib, ic, ie;

  // NOTE: combinational temporaries use blocking '=' so each line sees the
  // value produced by the line above it, exactly like the reference C code.
  always_comb begin
    fa = x_i ^ rot(x_i, FWD_ROT[0]);
    fb = y_i ^ rot(y_i, FWD_ROT[0]);
    fa = fa ^ rot(fa, FWD_ROT[1]);
    fb = fb ^ rot(fb, FWD_ROT[1]);
    fa = fa ^ rot(x_i, FWD_ROT[2]);
    fb = fb ^ rot(y_i, FWD_ROT[2]);
    fc = fa ^ rot(fa, FWD_ROT[3]);
    fe = fb ^ rot(fb, FWD_ROT[3]);
    fa = fa ^ rot(fe, FWD_ROT[4]);
    fb = fb ^ rot(fc, FWD_ROT[5]);
    fa = fa ^ rot(fc, FWD_ROT[6]);
    fb = fb ^ rot(fe, FWD_ROT[6]);
  end

  always_comb begin
    ia = x_i ^ rot(x_i, INV_ROT[0]);
    ib = y_i ^ rot(y_i, INV_ROT[0]);
    ic = x_i ^ rot(ia, INV_ROT[1]);
    ie = y_i ^ rot(ib, INV_ROT[1]);
    ic = ic ^ rot(ia, INV_ROT[2]);
    ie = ie ^ rot(ib, INV_ROT[2]);
    ia = ic ^ rot(ic, INV_ROT[3]);
    ib = ie ^ rot(ie, INV_ROT[3]);
    ic = ic ^ rot(ib, INV_ROT[4]);
    ie = ie ^ rot(ia, INV_ROT[5]);
    ia = ia ^ rot(ic, INV_ROT[6]);
    ib = ib ^ rot(ie, INV_ROT[6]);
  end

  assign a_o = inverse_i ? rot(ia, INV_ROT[7]) : fa;
  assign b_o = inverse_i ? rot(ib, INV_ROT[7]) : fb;

endmodule

// File: rtl/msk_lbox_engine.sv
// Serialised masked Clyde-128 L-box engine: latches a masked state, runs
// LANES word pairs per cycle through the L-box cores and holds the result.
module msk_lbox_engine
  import msk_lbox_pkg::*;
#(
  parameter int D     = 2,
  parameter int NPAIR = 2,
  parameter int LANES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  msk_lbox_if.slave  bus
);

  localparam int W      = 32 * D;
  localparam int SW     = 64 * NPAIR * D;
  localparam int STEPS  = NPAIR / LANES;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  fsm_e              fsm_q, fsm_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SW-1:0]     state_q, state_d;
  logic              inv_q, inv_d;

  logic [W-1:0] lane_x [LANES];
  logic [W-1:0] lane_y [LANES];
  logic [W-1:0] lane_a [LANES];
  logic [W-1:0] lane_b [LANES];

  // Lane l of step s works on pair s*LANES+l.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_x[l] = '0;
      lane_y[l] = '0;
      for (int s = 0; s < STEPS; s++) begin
        if (step_q == STEP_W'(s)) begin
          lane_x[l] = state_q[(2*(s*LANES+l))*W   +: W];
          lane_y[l] = state_q[(2*(s*LANES+l)+1)*W +: W];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    msk_lbox_core #(.D(D)) u_core (
      .inverse_i (inv_q),
      .x_i       (lane_x[l]),
      .y_i       (lane_y[l]),
      .a_o       (lane_a[l]),
      .b_o       (lane_b[l])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    fsm_d   = fsm_q;
    step_d  = step_q;
    state_d = state_q;
    inv_d   = inv_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.in_state;
          inv_d   = bus.in_inverse;
          step_d  = '0;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          for (int s = 0; s < STEPS; s++) begin
            if (step_q == STEP_W'(s)) begin
              state_d[(2*(s*LANES+l))*W   +: W] = lane_a[l];
              state_d[(2*(s*LANES+l)+1)*W +: W] = lane_b[l];
            end
          end
        end
        if (step_q == LAST_STEP) begin
          step_d = '0;
          fsm_d  = ST_DONE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // NOTE: the state register is reset too: a reset mid-operation must leave
  // no share material visible on out_state. Sequential state uses '<='.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      step_q  <= '0;
      state_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      step_q  <= step_d;
      state_q <= state_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.in_ready  = (fsm_q == ST_IDLE);
  assign bus.out_valid = (fsm_q == ST_DONE);
  assign bus.busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
  assign bus.out_state = state_q;

endmodule

// File: tb/tb_msk_lbox_engine.sv
// Self-checking bench for msk_lbox_engine: three configurations checked against
// an unmasked Clyde L-box model applied share by share.
module tb_msk_lbox_engine;

  typedef logic [767:0] big_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  msk_lbox_if #(.D(2), .NPAIR(2)) if0 ();
  msk_lbox_if #(.D(3), .NPAIR(4)) if1 ();
  msk_lbox_if #(.D(3), .NPAIR(4)) if2 ();

  msk_lbox_engine #(.D(2), .NPAIR(2), .LANES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  msk_lbox_engine #(.D(3), .NPAIR(4), .LANES(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  msk_lbox_engine #(.D(3), .NPAIR(4), .LANES(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input big_t obs, input big_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (unmasked Clyde L-box) ----------------
  function automatic logic [31:0] rr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic void lbox_fwd(input logic [31:0] x, y, output logic [31:0] ox, oy);
    logic [31:0] a, b, c, e;
    a = x ^ rr(x, 12);  b = y ^ rr(y, 12);
    a = a ^ rr(a, 3);   b = b ^ rr(b, 3);
    a = a ^ rr(x, 17);  b = b ^ rr(y, 17);
    c = a ^ rr(a, 31);  e = b ^ rr(b, 31);
    a = a ^ rr(e, 26);  b = b ^ rr(c, 25);
    a = a ^ rr(c, 15);  b = b ^ rr(e, 15);
    ox = a; oy = b;
  endfunction

  function automatic void lbox_inv(input logic [31:0] x, y, output logic [31:0] ox, oy);
    logic [31:0] a, b, c, e;
    a = x ^ rr(x, 25);  b = y ^ rr(y, 25);
    c = x ^ rr(a, 31);  e = y ^ rr(b, 31);
    c = c ^ rr(a, 20);  e = e ^ rr(b, 20);
    a = c ^ rr(c, 31);  b = e ^ rr(e, 31);
    c = c ^ rr(b, 26);  e = e ^ rr(a, 25);
    a = a ^ rr(c, 17);  b = b ^ rr(e, 17);
    ox = rr(a, 16); oy = rr(b, 16);
  endfunction

  function automatic logic [31:0] get_word(input big_t st, input int dd, input int w, input int j);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = st[w*32*dd + i*dd + j];
    return v;
  endfunction

  function automatic big_t put_word(input big_t st, input int dd, input int w, input int j,
                                    input logic [31:0] v);
    big_t r = st;
    for (int i = 0; i < 32; i++) r[w*32*dd + i*dd + j] = v[i];
    return r;
  endfunction

  function automatic logic [31:0] unmask(input big_t st, input int dd, input int w);
    logic [31:0] v = '0;
    for (int j = 0; j < dd; j++) v = v ^ get_word(st, dd, w, j);
    return v;
  endfunction

  // Linear map: the masked result is the L-box applied to every share alone.
  function automatic big_t model(input big_t st, input int dd, input int np, input bit inv);
    big_t r = '0;
    logic [31:0] ox, oy;
    for (int k = 0; k < np; k++)
      for (int j = 0; j < dd; j++) begin
        if (inv) lbox_inv(get_word(st, dd, 2*k, j), get_word(st, dd, 2*k+1, j), ox, oy);
        else     lbox_fwd(get_word(st, dd, 2*k, j), get_word(st, dd, 2*k+1, j), ox, oy);
        r = put_word(r, dd, 2*k, j, ox);
        r = put_word(r, dd, 2*k+1, j, oy);
      end
    return r;
  endfunction

  function automatic big_t rand_state(input int dd, input int np);
    big_t r = '0;
    for (int w = 0; w < 2*np; w++)
      for (int j = 0; j < dd; j++) r = put_word(r, dd, w, j, $urandom());
    return r;
  endfunction

  // ---------------- DUT access by configuration index ----------------
  task automatic set_in(input int sel, input bit v, input bit inv, input big_t st);
    case (sel)
      0:       begin if0.in_valid = v; if0.in_inverse = inv; if0.in_state = st[255:0]; end
      1:       begin if1.in_valid = v; if1.in_inverse = inv; if1.in_state = st; end
      default: begin if2.in_valid = v; if2.in_inverse = inv; if2.in_state = st; end
    endcase
  endtask

  task automatic set_ordy(input int sel, input bit r);
    case (sel)
      0:       if0.out_ready = r;
      1:       if1.out_ready = r;
      default: if2.out_ready = r;
    endcase
  endtask

  function automatic big_t get_out(input int sel);
    case (sel)
      0:       return big_t'(if0.out_state);
      1:       return if1.out_state;
      default: return if2.out_state;
    endcase
  endfunction

  function automatic bit get_ovalid(input int sel);
    case (sel)
      0:       return if0.out_valid;
      1:       return if1.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  // Count cycles from the accept edge until out_valid, bounded.
  task automatic wait_valid(input int sel, output int lat);
    lat = 0;
    while (!get_ovalid(sel) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Accept one state, then flip in_inverse and scramble in_state while running.
  task automatic run_op(input int sel, input big_t st, input bit inv, input int dd, input int np,
                        output big_t res, output int lat);
    set_in(sel, 1'b1, inv, st);
    @(posedge clk); #1;
    set_in(sel, 1'b0, ~inv, rand_state(dd, np));
    wait_valid(sel, lat);
    res = get_out(sel);
  endtask

  task automatic consume(input int sel);
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    big_t st, st2, res, exp, r1;
    big_t gold_unm, obs_unm, share0;
    int   lat;
    logic [31:0] gx, gy;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 1'b0, '0);
      set_ordy(s, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    check("rst_in_ready",  big_t'(if0.in_ready), 1);
    check("rst_out_valid", big_t'(if0.out_valid), 0);
    check("rst_busy",      big_t'(if0.busy), 0);
    check("rst_out_state", get_out(0), '0);
    check("rst_out_state_cfg1", get_out(1), '0);

    // All-zero state, forward: two RUN cycles, zero result.
    run_op(0, '0, 1'b0, 2, 2, res, lat);
    check("zero_latency", big_t'(lat), 2);
    check("zero_result", res, '0);
    consume(0);

    // Single set bit, share1 = 0.
    st = put_word('0, 2, 0, 0, 32'h0000_0001);
    run_op(0, st, 1'b0, 2, 2, res, lat);
    check("bit0_result", res, model(st, 2, 2, 1'b0));
    consume(0);

    // Same secret with random nonzero share1 masks.
    for (int it = 0; it < 3; it++) begin
      st = put_word('0, 2, 0, 0, 32'h0000_0001);
      for (int w = 0; w < 4; w++) begin
        logic [31:0] m;
        m = $urandom() | 32'h1;
        st = put_word(st, 2, w, 1, m);
        st = put_word(st, 2, w, 0, get_word(st, 2, w, 0) ^ m);
      end
      run_op(0, st, 1'b0, 2, 2, res, lat);
      check("masked_result", res, model(st, 2, 2, 1'b0));
      gold_unm = '0; obs_unm = '0; share0 = '0;
      for (int k = 0; k < 2; k++) begin
        lbox_fwd(unmask(st, 2, 2*k), unmask(st, 2, 2*k+1), gx, gy);
        gold_unm[64*k +: 64] = {gy, gx};
        obs_unm[64*k +: 64]  = {unmask(res, 2, 2*k+1), unmask(res, 2, 2*k)};
        share0[64*k +: 64]   = {get_word(res, 2, 2*k+1, 0), get_word(res, 2, 2*k, 0)};
      end
      check("masked_unmasked_golden", obs_unm, gold_unm);
      check("masked_share0_differs", big_t'(share0 !== gold_unm), 1);
      consume(0);
    end

    // Forward then inverse returns the original state.
    for (int it = 0; it < 4; it++) begin
      st = rand_state(2, 2);
      run_op(0, st, 1'b0, 2, 2, r1, lat);
      check("rt_fwd", r1, model(st, 2, 2, 1'b0));
      consume(0);
      run_op(0, r1, 1'b1, 2, 2, res, lat);
      check("rt_inv_latency", big_t'(lat), 2);
      check("rt_inv_back", res, st);
      consume(0);
    end

    // Back-pressure in DONE with a new request already waiting.
    st  = rand_state(2, 2);
    st2 = rand_state(2, 2);
    exp = model(st, 2, 2, 1'b0);
    run_op(0, st, 1'b0, 2, 2, res, lat);
    set_in(0, 1'b1, 1'b0, st2);
    for (int c = 0; c < 5; c++) begin
      check("stall_out_state", get_out(0), exp);
      check("stall_in_ready",  big_t'(if0.in_ready), 0);
      check("stall_out_valid", big_t'(if0.out_valid), 1);
      @(posedge clk); #1;
    end
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
    check("release_out_valid", big_t'(if0.out_valid), 0);
    check("release_in_ready",  big_t'(if0.in_ready), 1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b1, '0);
    check("b2b_busy", big_t'(if0.busy), 1);
    wait_valid(0, lat);
    check("b2b_latency", big_t'(lat), 2);
    check("b2b_result", get_out(0), model(st2, 2, 2, 1'b0));
    consume(0);

    // Reset asserted after the first RUN step.
    st = rand_state(2, 2);
    set_in(0, 1'b1, 1'b0, st);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", big_t'(if0.out_valid), 0);
    check("midrst_busy",      big_t'(if0.busy), 0);
    check("midrst_out_state", get_out(0), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", big_t'(if0.in_ready), 1);
    st = rand_state(2, 2);
    run_op(0, st, 1'b1, 2, 2, res, lat);
    check("postrst_latency", big_t'(lat), 2);
    check("postrst_result", res, model(st, 2, 2, 1'b1));
    consume(0);

    // Wider configurations: d=3, NPAIR=4 with 2 and 4 lanes.
    for (int sel = 1; sel <= 2; sel++) begin
      for (int it = 0; it < 3; it++) begin
        bit inv;
        inv = it[0];
        st  = rand_state(3, 4);
        run_op(sel, st, inv, 3, 4, res, lat);
        check("wide_latency", big_t'(lat), (sel == 1) ? 2 : 1);
        check("wide_result", res, model(st, 3, 4, inv));
        consume(sel);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
